write_coalescer: RTL and testbench

Write-side counterpart of the configurable-aspect-ratio SRAM read path. Accepts narrow writes (1/2/4/8/16/32 bits, chosen by conf) with a bit-granular address. Aligns each write into its lane of a 32-bit physical word and merges consecutive writes to the same word in a one-entry buffer. Emits full 32-bit word writes with a per-bit write mask to the 1k x 32 macro.

---
 rtl/write_coalescer.sv | 179 +++++++++++++++++
 tb/tb_write_coalescer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/write_coalescer.sv
// Narrow-write coalescer: aligns 1..32-bit writes into 32-bit words and merges
// consecutive writes to the same word before issuing one masked SRAM write.
module write_coalescer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned WORD_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         conf,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_AW+4:0] in_addr,
    input  logic [31:0]        in_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_AW-1:0] out_addr,
    output logic [31:0]        out_data,
    output logic [31:0]        out_mask,
    output logic               pending
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [WORD_AW-1:0] r_buf_addr;
    logic [31:0]        r_buf_data;
    logic [31:0]        r_buf_mask;
    logic [2:0]         r_buf_conf;
    logic [7:0]         r_cnt;
    logic               r_out_valid;
    logic [WORD_AW-1:0] r_out_addr;
    logic [31:0]        r_out_data;
    logic [31:0]        r_out_mask;

    logic [2:0]         w_k;
    logic [5:0]         w_width;
    logic [31:0]        w_wmask;
    logic [4:0]         w_lanemask;
    logic [4:0]         w_lane;
    logic [2:0]         w_lgw;
    logic [4:0]         w_pos;
    logic [31:0]        w_amask;
    logic [31:0]        w_adata;
    logic [WORD_AW-1:0] w_waddr;
    logic               w_hit;
    logic               w_accept;
    logic [31:0]        w_merged_data;
    logic [31:0]        w_merged_mask;

    logic [1:0]         w_nxt_state;
    logic [WORD_AW-1:0] w_nxt_addr;
    logic [31:0]        w_nxt_data;
    logic [31:0]        w_nxt_mask;
    logic [2:0]         w_nxt_conf;
    logic [7:0]         w_nxt_cnt;

    always_comb begin
        w_k        = (conf > 3'd5) ? 3'd0 : conf;
        w_width    = 6'd32 >> w_k;
        w_wmask    = 32'hFFFF_FFFF >> (6'd32 - w_width);
        // For k=5 the shift wraps to 0 and the subtraction yields 5'b11111, the full lane field.
        w_lanemask = (5'd1 << w_k) - 5'd1;
        w_lane     = in_addr[4:0] & w_lanemask;
        w_lgw      = 3'd5 - w_k;
        w_pos      = w_lane << w_lgw;
        w_amask    = w_wmask << w_pos;
        w_adata    = (in_data & w_wmask) << w_pos;
        w_waddr    = WORD_AW'(in_addr >> w_k);
    end

    assign w_hit         = (w_waddr == r_buf_addr) && (w_k == r_buf_conf);
    assign w_merged_data = (r_buf_data & ~w_amask) | w_adata;
    assign w_merged_mask = r_buf_mask | w_amask;

    always_comb begin
        case (r_state)
            S_EMPTY: in_ready = 1'b1;
            S_HOLD:  in_ready = w_hit;
            default: in_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_addr  = r_buf_addr;
        w_nxt_data  = r_buf_data;
        w_nxt_mask  = r_buf_mask;
        w_nxt_conf  = r_buf_conf;
        w_nxt_cnt   = r_cnt;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_nxt_addr  = w_waddr;
                    w_nxt_conf  = w_k;
                    w_nxt_data  = w_adata;
                    w_nxt_mask  = w_amask;
                    w_nxt_cnt   = '0;
                    w_nxt_state = (&w_amask) ? S_DRAIN : S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_accept) begin
                    w_nxt_data  = w_merged_data;
                    w_nxt_mask  = w_merged_mask;
                    w_nxt_cnt   = '0;
                    w_nxt_state = ((&w_merged_mask) || flush) ? S_DRAIN : S_HOLD;
                end else if (in_valid || flush) begin
                    // An unaccepted valid request here is a miss; it waits out the drain.
                    w_nxt_state = S_DRAIN;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_nxt_state = S_DRAIN;
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            S_DRAIN: begin
                if (r_out_valid && out_ready) begin
                    w_nxt_state = S_EMPTY;
                    w_nxt_addr  = '0;
                    w_nxt_data  = '0;
                    w_nxt_mask  = '0;
                    w_nxt_conf  = '0;
                    w_nxt_cnt   = '0;
                end
            end
            default: w_nxt_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_buf_mask <= '0;
            r_buf_conf <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_buf_addr <= w_nxt_addr;
            r_buf_data <= w_nxt_data;
            r_buf_mask <= w_nxt_mask;
            r_buf_conf <= w_nxt_conf;
            r_cnt      <= w_nxt_cnt;
        end
    end

    // Output registers mirror the next buffer whenever the next state is DRAIN, else zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
        end else if (w_nxt_state == S_DRAIN) begin
            r_out_valid <= 1'b1;
            r_out_addr  <= w_nxt_addr;
            r_out_data  <= w_nxt_data;
            r_out_mask  <= w_nxt_mask;
        end else begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_mask  = r_out_mask;
    assign pending   = (r_state != S_EMPTY);

endmodule

// File: tb/tb_write_coalescer.sv
// Directed bench for write_coalescer: hand-computed vectors, immediate-assertion checks.
module tb_write_coalescer;

    localparam int unsigned AW = 10;

    logic          clk;
    logic          rst;
    logic [2:0]    conf;
    logic          in_valid;
    logic          in_ready;
    logic [AW+4:0] in_addr;
    logic [31:0]   in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_data;
    logic [31:0]   out_mask;
    logic          pending;

    int n_total;
    int n_fail;
    int n_seen;

    write_coalescer #(.TIMEOUT(16), .WORD_AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .conf     (conf),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_mask (out_mask),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_total   = 0;
        n_fail    = 0;
        n_seen    = 0;
        rst       = 1'b1;
        conf      = 3'd0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pending",   32'(pending),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_mask",  out_mask,       32'd0);
        rst = 1'b0;
        tick();

        // 1: four x8 writes fill word 1
        conf = 3'd2; in_valid = 1'b1;
        in_addr = 15'h004; in_data = 32'h11; tick();
        in_addr = 15'h005; in_data = 32'h22; tick();
        in_addr = 15'h006; in_data = 32'h33; tick();
        chk("t1_no_early_write", 32'(out_valid), 32'd0);
        in_addr = 15'h007; in_data = 32'h44; #1;
        chk("t1_in_ready_hit", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_addr",  32'(out_addr),  32'd1);
        chk("t1_out_data",  out_data,       32'h44332211);
        chk("t1_out_mask",  out_mask,       32'hFFFFFFFF);
        tick();
        chk("t1_single_write", 32'(out_valid), 32'd0);
        chk("t1_pending_clr",  32'(pending),   32'd0);

        // 2: full-word write drains immediately
        conf = 3'd0; in_valid = 1'b1; in_addr = 15'd3; in_data = 32'hDEADBEEF;
        tick();
        in_valid = 1'b0; #1;
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_out_addr",  32'(out_addr),  32'd3);
        chk("t2_out_data",  out_data,       32'hDEADBEEF);
        chk("t2_out_mask",  out_mask,       32'hFFFFFFFF);
        chk("t2_in_ready",  32'(in_ready),  32'd0);
        tick();
        chk("t2_done", 32'(out_valid), 32'd0);

        // 3: x16 miss to a different word forces a drain
        conf = 3'd1; in_valid = 1'b1; in_addr = 15'd0; in_data = 32'hABCD;
        tick();
        in_addr = 15'd2; in_data = 32'h1234; #1;
        chk("t3_miss_not_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        chk("t3_out_addr",  32'(out_addr),  32'd0);
        chk("t3_out_data",  out_data,       32'h0000ABCD);
        chk("t3_out_mask",  out_mask,       32'h0000FFFF);
        chk("t3_drain_not_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t3_retry_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_second_addr", 32'(out_addr), 32'd1);
        chk("t3_second_data", out_data,      32'h00001234);
        chk("t3_second_mask", out_mask,      32'h0000FFFF);
        tick();

        // 4: x1 write, idle timeout after 16 cycles
        conf = 3'd5; in_valid = 1'b1; in_addr = 15'd5; in_data = 32'h1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t4_not_yet",  32'(out_valid), 32'd0);
        chk("t4_pending",  32'(pending),   32'd1);
        tick();
        chk("t4_out_valid", 32'(out_valid), 32'd1);
        chk("t4_out_addr",  32'(out_addr),  32'd0);
        chk("t4_out_data",  out_data,       32'h00000020);
        chk("t4_out_mask",  out_mask,       32'h00000020);
        tick();

        // 5: x4 overlap, flush, backpressure
        conf = 3'd3; in_valid = 1'b1; in_addr = 15'd0; in_data = 32'h3;
        tick();
        in_data = 32'h5;
        tick();
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b0;
        tick();
        flush = 1'b0;
        chk("t5_out_data", out_data, 32'h00000005);
        chk("t5_out_mask", out_mask, 32'h0000000F);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_data",  out_data,       32'h00000005);
            chk("t5_hold_mask",  out_mask,       32'h0000000F);
            chk("t5_hold_pend",  32'(pending),   32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("t5_released_valid", 32'(out_valid), 32'd0);
        chk("t5_released_pend",  32'(pending),   32'd0);

        // 6: reset during HOLD drops the buffer
        conf = 3'd4; in_valid = 1'b1; in_addr = 15'd0; in_data = 32'h1;
        tick();
        in_valid = 1'b0;
        chk("t6_holding", 32'(pending), 32'd1);
        rst = 1'b1; #1;
        chk("t6_rst_valid",    32'(out_valid), 32'd0);
        chk("t6_rst_pending",  32'(pending),   32'd0);
        chk("t6_rst_in_ready", 32'(in_ready),  32'd1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (out_valid) n_seen++;
        end
        chk("t6_no_write_after_rst", 32'(n_seen), 32'd0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
